// File: rtl/fragment_hazard_scheduler.sv
// Fragment hazard scheduler: holds back a fragment whose framebuffer index is still in flight.
// Optional stall statistics counter is enabled by defining FRAGMENT_HAZARD_STATS_EN.
module fragment_hazard_scheduler #(
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int PAYLOAD_WIDTH           = 64,
    parameter int ENTRIES                 = 8
) (
    input  logic                               aclk,
    input  logic                               reset,
    input  logic                               s_frag_tvalid,
    output logic                               s_frag_tready,
    input  logic                               s_frag_tlast,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_tindex,
    input  logic [PAYLOAD_WIDTH-1:0]           s_frag_tpayload,
    output logic                               m_frag_tvalid,
    input  logic                               m_frag_tready,
    output logic                               m_frag_tlast,
    output logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_frag_tindex,
    output logic [PAYLOAD_WIDTH-1:0]           m_frag_tpayload,
    input  logic                               wr_valid,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] wr_addr,
    output logic                               idle,
    output logic                               orderError,
    output logic [$clog2(ENTRIES):0]           inFlight
`ifdef FRAGMENT_HAZARD_STATS_EN
    ,
    output logic [31:0]                        stallCycles
`endif
);

    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(ENTRIES) + 1;

    logic [ENTRIES-1:0]                 ent_valid;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] ent_index [ENTRIES];
    logic [AW-1:0]                      head;
    logic [AW-1:0]                      tail;
    logic [CW-1:0]                      count;

    logic retire;
    logic full;
    logic hit;
    logic hazard;
    logic issue;

    assign retire = wr_valid & (count != '0);
    assign full   = (count == CW'(ENTRIES));

    // The head entry being retired this cycle no longer blocks its index.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_valid[i] && (ent_index[i] == s_frag_tindex) &&
                !(retire && (head == AW'(i)))) begin
                hit = 1'b1;
            end
        end
    end

    assign hazard = s_frag_tvalid & hit;
    assign issue  = ~reset & s_frag_tvalid & ~hazard & (~full | retire) &
                    (~m_frag_tvalid | m_frag_tready);

    assign s_frag_tready = issue;
    assign inFlight      = count;
    assign idle          = (count == '0) & ~m_frag_tvalid;

    always_ff @(posedge aclk) begin
        if (reset) begin
            ent_valid       <= '0;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            orderError      <= 1'b0;
            m_frag_tvalid   <= 1'b0;
            m_frag_tlast    <= 1'b0;
            m_frag_tindex   <= '0;
            m_frag_tpayload <= '0;
        end else begin
            if (retire) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
                if (wr_addr != ent_index[head]) begin
                    orderError <= 1'b1;
                end
            end else if (wr_valid) begin
                orderError <= 1'b1;
            end

            // Issue after retire so a full-table swap at head == tail leaves the slot valid.
            if (issue) begin
                ent_valid[tail] <= 1'b1;
                ent_index[tail] <= s_frag_tindex;
                tail            <= tail + 1'b1;
                m_frag_tvalid   <= 1'b1;
                m_frag_tlast    <= s_frag_tlast;
                m_frag_tindex   <= s_frag_tindex;
                m_frag_tpayload <= s_frag_tpayload;
            end else if (m_frag_tready) begin
                m_frag_tvalid <= 1'b0;
            end

            count <= count + CW'(issue) - CW'(retire);
        end
    end

`ifdef FRAGMENT_HAZARD_STATS_EN
    always_ff @(posedge aclk) begin
        if (reset) begin
            stallCycles <= '0;
        end else if (hazard && (stallCycles != '1)) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule
